// File: rtl/digital_control_block.sv
// Serial frame parser for one chip of a daisy-chained RGB LED driver: matches a header,
// captures this chip's payload into B/G/R words and forwards the rest of the stream.
module digital_control_block #(
    parameter int HDR_W   = 16,
    parameter int PAY_W   = 39,
    parameter int COLOR_W = 12
) (
    input  logic               recoveredCLK,
    input  logic               globalReset,
    input  logic               reData,
    input  logic [HDR_W-1:0]   REF16Bits,
    input  logic [5:0]         REF6Bit,
    output logic               dataOut,
    output logic [COLOR_W-1:0] Bdata,
    output logic [COLOR_W-1:0] Gdata,
    output logic [COLOR_W-1:0] Rdata
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam int DRAIN_W = $clog2(HDR_W);

    state_t               r_state;
    state_t               w_next_state;
    logic [HDR_W-1:0]     r_hreg;
    logic [PAY_W-1:0]     r_payload;
    logic [5:0]           r_cnt;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [COLOR_W-1:0]   r_bdata;
    logic [COLOR_W-1:0]   r_gdata;
    logic [COLOR_W-1:0]   r_rdata;

    logic w_match;
    logic w_last_drain;
    logic w_hreg_en;
    logic w_pay_en;
    logic w_cnt_start;
    logic w_load_colors;

    assign w_match      = (r_hreg == REF16Bits) && (REF6Bit != 6'd0);
    assign w_last_drain = (r_drain_cnt == DRAIN_W'(HDR_W - 1));

    always_ff @(posedge recoveredCLK or negedge globalReset) begin
        if (!globalReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_next_state  = r_state;
        w_hreg_en     = 1'b0;
        w_pay_en      = 1'b0;
        w_cnt_start   = 1'b0;
        w_load_colors = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_match) begin
                    w_pay_en     = 1'b1;
                    w_cnt_start  = 1'b1;
                    w_next_state = (REF6Bit == 6'd1) ? DRAIN : CAPTURE;
                end else begin
                    w_hreg_en = 1'b1;
                end
            end
            CAPTURE: begin
                // Header stays frozen in hreg, so dataOut stretches the header's first bit.
                w_pay_en = 1'b1;
                if (r_cnt + 6'd1 == REF6Bit) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                // Match is ignored while the held header shifts out, avoiding a re-trigger.
                w_hreg_en     = 1'b1;
                w_load_colors = (r_drain_cnt == '0);
                if (w_last_drain) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge recoveredCLK or negedge globalReset) begin
        if (!globalReset) begin
            r_hreg      <= '0;
            r_payload   <= '0;
            r_cnt       <= '0;
            r_drain_cnt <= '0;
            r_bdata     <= '0;
            r_gdata     <= '0;
            r_rdata     <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register see pre-edge values of the others.
            if (w_hreg_en) begin
                r_hreg <= {reData, r_hreg[HDR_W-1:1]};
            end
            if (w_pay_en) begin
                r_payload <= {reData, r_payload[PAY_W-1:1]};
            end
            if (w_cnt_start) begin
                r_cnt <= 6'd1;
            end else if (r_state == CAPTURE) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= w_last_drain ? '0 : r_drain_cnt + DRAIN_W'(1);
            end
            // Each 13-bit field carries its guard bit in the LSB position, which is dropped.
            if (w_load_colors) begin
                r_rdata <= r_payload[COLOR_W:1];
                r_gdata <= r_payload[2*COLOR_W+1:COLOR_W+2];
                r_bdata <= r_payload[3*COLOR_W+2:2*COLOR_W+3];
            end
        end
    end

    assign dataOut = r_hreg[0];
    assign Bdata   = r_bdata;
    assign Gdata   = r_gdata;
    assign Rdata   = r_rdata;

endmodule

// File: tb/tb_digital_control_block.sv
// Directed bench for digital_control_block: two cascaded instances, frame streams built LSB-first.
module tb_digital_control_block;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re_data = 1'b0;
    logic [15:0] ref16 = 16'hFFFE;
    logic [5:0]  ref6 = 6'd39;
    logic        out_a, out_b;
    logic [11:0] b_a, g_a, r_a, b_b, g_b, r_b;

    int errors = 0;
    int checks = 0;

    bit          stim[$];
    bit          obs_a[$];
    bit          obs_b[$];
    logic [35:0] col_a[$];
    logic [35:0] col_b[$];

    always #5 clk = ~clk;

    digital_control_block dut_a (
        .recoveredCLK(clk), .globalReset(rst_n), .reData(re_data),
        .REF16Bits(ref16), .REF6Bit(ref6), .dataOut(out_a),
        .Bdata(b_a), .Gdata(g_a), .Rdata(r_a)
    );

    digital_control_block dut_b (
        .recoveredCLK(clk), .globalReset(rst_n), .reData(out_a),
        .REF16Bits(ref16), .REF6Bit(ref6), .dataOut(out_b),
        .Bdata(b_b), .Gdata(g_b), .Rdata(r_b)
    );

    task automatic push_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) stim.push_back(v[i]);
    endtask

    task automatic push_field(input logic [11:0] v);
        push_bits({3'b000, v, 1'b0}, 13);
    endtask

    // obs_x[k] is dataOut just before edge k; col_x[k] is the colour triple {B,G,R} just after edge k.
    task automatic run_stim();
        obs_a.delete(); obs_b.delete(); col_a.delete(); col_b.delete();
        for (int i = 0; i < stim.size(); i++) begin
            obs_a.push_back(out_a);
            obs_b.push_back(out_b);
            re_data = stim[i];
            @(posedge clk); #1;
            col_a.push_back({b_a, g_a, r_a});
            col_b.push_back({b_b, g_b, r_b});
        end
        re_data = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        re_data = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (10) begin
            re_data = 1'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if ({b_a, g_a, r_a} !== 36'h0) begin
            errors++; $display("FAIL reset_colors_a: got %h expected %h", {b_a, g_a, r_a}, 36'h0);
        end
        checks++;
        if ({b_b, g_b, r_b} !== 36'h0) begin
            errors++; $display("FAIL reset_colors_b: got %h expected %h", {b_b, g_b, r_b}, 36'h0);
        end
        checks++;
        if (out_a !== 1'b0 || out_b !== 1'b0) begin
            errors++; $display("FAIL reset_dataout: got %b%b expected 00", out_a, out_b);
        end
        re_data = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic build_single_frame();
        stim.delete();
        push_bits(16'h0, 2);
        push_bits(16'hFFFE, 16);
        repeat (3) push_field(12'hAAA);
        repeat (3) push_field(12'hFFF);
        push_bits(16'h0, 16); push_bits(16'h0, 16); push_bits(16'h0, 16); push_bits(16'h0, 7);
    endtask

    task automatic test_single_frame();
        bit exp;
        apply_reset();
        build_single_frame();
        run_stim();
        checks++;
        if (col_a[56] !== 36'h0) begin
            errors++; $display("FAIL single_before_load: got %h expected %h", col_a[56], 36'h0);
        end
        checks++;
        if (col_a[57] !== {3{12'hAAA}}) begin
            errors++; $display("FAIL single_load_edge: got %h expected %h", col_a[57], {3{12'hAAA}});
        end
        // 40 lows (header 0 stretched by 39 capture cycles), 15 header ones, then stream after payload.
        for (int k = 0; k < obs_a.size(); k++) begin
            if (k >= 58 && k <= 72) exp = 1'b1;
            else if (k >= 73)      exp = stim[k-16];
            else                   exp = 1'b0;
            checks++;
            if (obs_a[k] !== exp) begin
                errors++; $display("FAIL single_dataout[%0d]: got %b expected %b", k, obs_a[k], exp);
            end
        end
    endtask

    task automatic test_cascade();
        bit exp;
        apply_reset();
        build_single_frame();
        run_stim();
        checks++;
        if (col_a[col_a.size()-1] !== {3{12'hAAA}}) begin
            errors++; $display("FAIL cascade_a_colors: got %h expected %h", col_a[col_a.size()-1], {3{12'hAAA}});
        end
        checks++;
        if (col_b[111] !== 36'h0 || col_b[112] !== {3{12'hFFF}}) begin
            errors++; $display("FAIL cascade_b_load: got %h,%h expected %h,%h", col_b[111], col_b[112], 36'h0, {3{12'hFFF}});
        end
        for (int k = 0; k < obs_b.size(); k++) begin
            exp = (k >= 113 && k <= 127);
            checks++;
            if (obs_b[k] !== exp) begin
                errors++; $display("FAIL cascade_b_dataout[%0d]: got %b expected %b", k, obs_b[k], exp);
            end
        end
    endtask

    task automatic test_no_header();
        int  run;
        bit  b;
        bit  changed;
        stim.delete();
        run = 0;
        for (int i = 0; i < 200; i++) begin
            b = 1'($urandom);
            if (run == 12) b = 1'b0;
            run = b ? run + 1 : 0;
            stim.push_back(b);
        end
        run_stim();
        changed = 1'b0;
        for (int k = 0; k < col_a.size(); k++) begin
            if (col_a[k] !== {3{12'hAAA}} || col_b[k] !== {3{12'hFFF}}) changed = 1'b1;
        end
        checks++;
        if (changed) begin
            errors++; $display("FAIL nohdr_colors_held: got a=%h b=%h expected a=%h b=%h",
                               col_a[col_a.size()-1], col_b[col_b.size()-1], {3{12'hAAA}}, {3{12'hFFF}});
        end
        for (int k = 0; k < obs_a.size(); k++) begin
            b = (k >= 16) ? stim[k-16] : 1'b0;
            checks++;
            if (obs_a[k] !== b) begin
                errors++; $display("FAIL nohdr_delay16[%0d]: got %b expected %b", k, obs_a[k], b);
            end
        end
    endtask

    task automatic test_reset_mid_capture();
        stim.delete();
        push_bits(16'h0, 2);
        push_bits(16'hFFFE, 16);
        push_field(12'hAAA);
        push_field(12'hAAA);
        while (stim.size() > 38) void'(stim.pop_back());
        run_stim();
        checks++;
        if (col_a[col_a.size()-1] !== {3{12'hAAA}}) begin
            errors++; $display("FAIL midcap_precondition: got %h expected %h", col_a[col_a.size()-1], {3{12'hAAA}});
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({b_a, g_a, r_a} !== 36'h0 || {b_b, g_b, r_b} !== 36'h0) begin
            errors++; $display("FAIL midcap_reset_colors: got a=%h b=%h expected 0", {b_a, g_a, r_a}, {b_b, g_b, r_b});
        end
        checks++;
        if (out_a !== 1'b0) begin
            errors++; $display("FAIL midcap_reset_dataout: got %b expected 0", out_a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stim.delete();
        push_bits(16'h0, 2);
        push_bits(16'hFFFE, 16);
        repeat (3) push_field(12'h001);
        push_bits(16'h0, 16);
        run_stim();
        checks++;
        if (col_a[col_a.size()-1] !== {3{12'h001}}) begin
            errors++; $display("FAIL midcap_next_frame: got %h expected %h", col_a[col_a.size()-1], {3{12'h001}});
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        stim.delete();
        push_bits(16'h0, 2);
        push_bits(16'hFFFE, 16);
        repeat (3) push_field(12'hAAA);
        push_bits(16'hFFFE, 16);
        push_field(12'h123);
        push_field(12'h456);
        push_field(12'h789);
        push_bits(16'h0, 16);
        run_stim();
        checks++;
        if (col_a[57] !== {3{12'hAAA}}) begin
            errors++; $display("FAIL b2b_frame1: got %h expected %h", col_a[57], {3{12'hAAA}});
        end
        checks++;
        if (col_a[111] !== {3{12'hAAA}}) begin
            errors++; $display("FAIL b2b_hold: got %h expected %h", col_a[111], {3{12'hAAA}});
        end
        checks++;
        if (col_a[112] !== {12'h789, 12'h456, 12'h123}) begin
            errors++; $display("FAIL b2b_frame2: got %h expected %h", col_a[112], {12'h789, 12'h456, 12'h123});
        end
    endtask

    task automatic test_ref6_short();
        bit exp;
        ref6 = 6'd13;
        apply_reset();
        stim.delete();
        push_bits(16'h0, 2);
        push_bits(16'hFFFE, 16);
        push_field(12'h5A5);
        push_bits(16'h0, 16);
        push_bits(16'h0, 4);
        run_stim();
        checks++;
        if (col_a[30] !== 36'h0 || col_a[31] !== {12'h5A5, 24'h0}) begin
            errors++; $display("FAIL ref6_13_colors: got %h,%h expected %h,%h", col_a[30], col_a[31], 36'h0, {12'h5A5, 24'h0});
        end
        for (int k = 0; k < obs_a.size(); k++) begin
            exp = (k >= 32 && k <= 46);
            checks++;
            if (obs_a[k] !== exp) begin
                errors++; $display("FAIL ref6_13_dataout[%0d]: got %b expected %b", k, obs_a[k], exp);
            end
        end
        ref6 = 6'd39;
    endtask

    task automatic test_ref6_zero();
        bit exp;
        ref6 = 6'd0;
        apply_reset();
        stim.delete();
        push_bits(16'h0, 2);
        push_bits(16'hFFFE, 16);
        repeat (3) push_field(12'hAAA);
        push_bits(16'h0, 10);
        run_stim();
        checks++;
        if (col_a[col_a.size()-1] !== 36'h0) begin
            errors++; $display("FAIL ref6_0_colors: got %h expected %h", col_a[col_a.size()-1], 36'h0);
        end
        for (int k = 0; k < obs_a.size(); k++) begin
            exp = (k >= 16) ? stim[k-16] : 1'b0;
            checks++;
            if (obs_a[k] !== exp) begin
                errors++; $display("FAIL ref6_0_delay16[%0d]: got %b expected %b", k, obs_a[k], exp);
            end
        end
        ref6 = 6'd39;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_cascade();
        test_no_header();
        test_reset_mid_capture();
        test_back_to_back();
        test_ref6_short();
        test_ref6_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digital_control_block.md
Name: digital_control_block

Overview:
- Per-LED-chip serial frame parser in a daisy-chained RGB LED driver, clocked by the recovered bit clock from the Manchester decoder.
- Watches the recovered serial stream for a 16-bit frame header and claims the REF6Bit payload bits that follow.
- Latches the payload into 12-bit B/G/R words.
- Forwards the header plus all remaining bits, minus its own payload, to the next chip.

Parameters:
- HDR_W, 16, header / forwarding shift-register width
- PAY_W, 39, payload register width (3 fields x 13 bits)
- COLOR_W, 12, colour word width

Ports:
- recoveredCLK  in  1  bit clock; all state updates on rising edge
- globalReset  in  1  asynchronous, active-low reset
- reData  in  1  serial data, one bit per recoveredCLK
- REF16Bits  in  16  header pattern to match (nominal 16'hFFFE)
- REF6Bit  in  6  payload length in bits (nominal 39)
- dataOut  out  1  serial stream to next chip
- Bdata  out  12  blue word
- Gdata  out  12  green word
- Rdata  out  12  red word

Behaviour:
- Single clock domain (recoveredCLK) using clock enables; no gated clocks.
- Reset (globalReset=0, async) clears:
  - hreg[15:0], payload[38:0], bit counter, drain counter
  - Bdata, Gdata, Rdata, dataOut → 0
  - state → IDLE
- hreg shifting:
  - When enabled, each edge does hreg <= {reData, hreg[15:1]}.
  - The oldest received bit sits at hreg[0].
  - dataOut = hreg[0] (registered-path output).
- match = (hreg == REF16Bits) && (REF6Bit != 0).
  - The header is sent LSB first: 0 followed by fifteen 1s.
- State machine:
  - IDLE:
    - match=0: shift hreg.
    - match=1: hold hreg; payload <= {reData, payload[38:1]}; cnt <= 1. If REF6Bit==1 go to DRAIN, else go to CAPTURE.
  - CAPTURE:
    - Hold hreg, so dataOut is frozen at hreg[0] (=0 for nominal header).
    - Shift reData into payload MSB each edge; cnt++.
    - On the edge capturing bit number REF6Bit, go to DRAIN.
  - DRAIN:
    - On entry edge, load colours: Rdata <= payload[12:1], Gdata <= payload[25:14], Bdata <= payload[38:27].
    - payload[0], [13], [26] are guard bits and are discarded.
    - Shift hreg for 16 edges with match ignored, then go to IDLE.
    - This prevents re-triggering on the held header.
- Payload bit order:
  - The first received payload bit ends at payload[0].
  - Field value = 13-bit field with its LSB guard bit dropped. Example: 1010101010100 → 12'hAAA.
- Pass-through:
  - In IDLE/DRAIN, dataOut = reData delayed 16 cycles.
  - Downstream sees: the header (first 0 stretched by the capture window), then the bits following this chip's payload.
- Guard bits cap payload runs of 1s at 12, so no false header occurs inside a payload.
- REF6Bit≠39: the freeze length follows REF6Bit and the colour mapping from payload is unchanged. REF6Bit=0: block is a pure 16-cycle delay and never captures.
- Colour outputs hold until the next completed capture or reset.
- Reset mid-CAPTURE: outputs return to 0 and the partial payload is discarded.
- Size: ~150–250 lines of RTL.

Test Plan:
1. Reset: assert globalReset=0 for 10 cycles with random reData → Bdata=Gdata=Rdata=0, dataOut=0, state IDLE.
2. Single frame:
   - Stimulus: REF16Bits=16'hFFFE, REF6Bit=39; feed LSB-first 2'b00, header, payload 3×13'b1010101010100, then 3×13'b1111111111110, then 55 zeros.
   - Required: Bdata=Gdata=Rdata=12'hAAA one edge after the 39th payload bit.
   - Required on dataOut: low for 39 cycles, then 0 + fifteen 1s, then the 0xFFF payload bits, then zeros.
3. Cascade: feed instance A's dataOut into instance B with the same REF inputs and the step 2 stream → A outputs 12'hAAA, B outputs 12'hFFF; B's dataOut carries header + zeros only.
4. No header: 200 bits of random data with guard-bit-limited runs of ≤12 ones → no colour change; dataOut equals reData delayed exactly 16 cycles.
5. Reset mid-capture: assert globalReset after 20 payload bits → outputs 0; a following complete frame with 3×13'b0000000000010 yields 12'h001 on all colours.
6. Back-to-back frames: frame 1 (0xAAA) then frame 2 with distinct fields R=0x123, G=0x456, B=0x789 → colours update to the frame 2 values, proving field ordering and re-arm after DRAIN.
